// File: rtl/pi_estimator.sv
// Monte Carlo pi estimator: classifies LFSR sample points against a circle,
// counts hits/totals and divides 4*hits/total into an unsigned Q3.13 estimate.
module pi_estimator #(
   parameter int unsigned RADIUS  = 240,
   parameter int unsigned COUNT_W = 20
) (
   input  logic               clk10,
   input  logic               reset,
   input  logic               sample_stb,
   input  logic [8:0]         x_in,
   input  logic [8:0]         y_in,
   output logic [COUNT_W-1:0] hit_cnt,
   output logic [COUNT_W-1:0] total_cnt,
   output logic [15:0]        pi_est,
   output logic               est_valid,
   output logic               busy,
   output logic               overrun,
   output logic               saturated
);

   localparam int unsigned DW   = COUNT_W + 15;
   localparam int unsigned BC_W = $clog2(DW + 1);
   localparam logic [9:0]  R_10 = 10'(RADIUS);
   localparam logic [9:0]  SPAN = 10'(2 * RADIUS);
   localparam logic [17:0] R_SQ = 18'(RADIUS * RADIUS);
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {IDLE, CALC, ACCUM, DIV, DONE} state_t;

   state_t state, state_nxt;

   logic [8:0]          x_r, y_r;
   logic                in_circ_r;
   logic signed [9:0]   dx, dy;
   logic [8:0]          adx, ady;
   logic [17:0]         dist_sq;
   logic                in_sq, in_circ;
   logic [COUNT_W-1:0]  total_nxt, hit_nxt;
   logic [DW-1:0]       dividend;
   logic [COUNT_W-1:0]  divisor;
   logic [COUNT_W-1:0]  rem;
   logic [COUNT_W:0]    rem_sh, rem_nxt;
   logic                q_bit;
   logic [15:0]         quot;
   logic [BC_W-1:0]     bit_cnt;
   logic                unused_rem_msb;

   // Point classification; |dx|,|dy| <= 271 so the distance sum fits 18 bits
   always_comb begin
      dx      = $signed({1'b0, x_r}) - $signed(R_10);
      dy      = $signed({1'b0, y_r}) - $signed(R_10);
      adx     = 9'(dx[9] ? -dx : dx);
      ady     = 9'(dy[9] ? -dy : dy);
      dist_sq = ({9'd0, adx} * {9'd0, adx}) + ({9'd0, ady} * {9'd0, ady});
      in_sq   = ({1'b0, x_r} <= SPAN) && ({1'b0, y_r} <= SPAN);
      in_circ = in_sq && (dist_sq <= R_SQ);
   end

   // Saturating counter increments
   always_comb begin
      total_nxt = (total_cnt == CNT_MAX) ? total_cnt : total_cnt + COUNT_W'(1);
      hit_nxt   = (in_circ_r && (hit_cnt != CNT_MAX)) ? hit_cnt + COUNT_W'(1) : hit_cnt;
   end

   // One restoring-division step; the remainder stays below the divisor
   always_comb begin
      rem_sh         = {rem, dividend[DW-1]};
      q_bit          = (rem_sh >= {1'b0, divisor});
      rem_nxt        = q_bit ? (rem_sh - {1'b0, divisor}) : rem_sh;
      unused_rem_msb = rem_nxt[COUNT_W];
   end

   always_ff @(posedge clk10) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sample_stb && !saturated) state_nxt = CALC;
         CALC:    state_nxt = in_sq ? ACCUM : IDLE;
         ACCUM:   state_nxt = DIV;
         DIV:     if (bit_cnt == BC_W'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk10) begin
      if (reset) begin
         x_r       <= '0;
         y_r       <= '0;
         in_circ_r <= 1'b0;
         hit_cnt   <= '0;
         total_cnt <= '0;
         pi_est    <= '0;
         est_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         saturated <= 1'b0;
         dividend  <= '0;
         divisor   <= '0;
         rem       <= '0;
         quot      <= '0;
         bit_cnt   <= '0;
      end else begin
         est_valid <= 1'b0;
         busy      <= (state_nxt != IDLE);
         saturated <= (total_cnt == CNT_MAX);
         if (sample_stb && (state != IDLE)) overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (sample_stb && !saturated) begin
                  x_r <= x_in;
                  y_r <= y_in;
               end
            end
            CALC: in_circ_r <= in_circ;
            ACCUM: begin
               total_cnt <= total_nxt;
               hit_cnt   <= hit_nxt;
               dividend  <= {hit_nxt, 15'd0};
               divisor   <= total_nxt;
               rem       <= '0;
               quot      <= '0;
               bit_cnt   <= BC_W'(DW);
            end
            // Quotient never exceeds 0x8000, so bits shifted past bit 15 are zero
            DIV: begin
               dividend <= dividend << 1;
               rem      <= rem_nxt[COUNT_W-1:0];
               quot     <= {quot[14:0], q_bit};
               bit_cnt  <= bit_cnt - BC_W'(1);
            end
            DONE: begin
               pi_est    <= quot;
               est_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pi_estimator.sv
// Self-checking bench for pi_estimator: directed vector table on the default
// configuration plus overrun, saturation (COUNT_W=4) and mid-divide reset sequences.
module tb_pi_estimator;

   logic        clk10 = 1'b0;
   logic        reset;
   logic        stb_a, stb_b;
   logic [8:0]  x, y;
   logic [19:0] hit_a, total_a;
   logic [15:0] pi_a, pi_b;
   logic [3:0]  hit_b, total_b;
   logic        est_valid_a, busy_a, overrun_a, saturated_a;
   logic        est_valid_b, busy_b, overrun_b, saturated_b;

   int checks   = 0;
   int failures = 0;

   always #50 clk10 = ~clk10;

   pi_estimator #(.RADIUS(240), .COUNT_W(20)) dut_a (
      .clk10(clk10), .reset(reset), .sample_stb(stb_a), .x_in(x), .y_in(y),
      .hit_cnt(hit_a), .total_cnt(total_a), .pi_est(pi_a), .est_valid(est_valid_a),
      .busy(busy_a), .overrun(overrun_a), .saturated(saturated_a));

   pi_estimator #(.RADIUS(240), .COUNT_W(4)) dut_b (
      .clk10(clk10), .reset(reset), .sample_stb(stb_b), .x_in(x), .y_in(y),
      .hit_cnt(hit_b), .total_cnt(total_b), .pi_est(pi_b), .est_valid(est_valid_b),
      .busy(busy_b), .overrun(overrun_b), .saturated(saturated_b));

   typedef struct {
      int x;
      int y;
      bit valid;
      int hit;
      int total;
      int pi;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Pulse one strobe on the selected DUT; returns at the negedge of the next cycle
   task automatic strobe(input bit sel_b, input int xv, input int yv);
      @(negedge clk10);
      x = 9'(xv);
      y = 9'(yv);
      if (sel_b) stb_b = 1'b1;
      else       stb_a = 1'b1;
      @(negedge clk10);
      stb_a = 1'b0;
      stb_b = 1'b0;
   endtask

   // Cycles from the strobe cycle to est_valid, or -1 if none within limit
   task automatic wait_valid(input bit sel_b, input int limit, output int cyc);
      cyc = 1;
      while (!(sel_b ? est_valid_b : est_valid_a) && cyc < limit) begin
         @(negedge clk10);
         cyc++;
      end
      if (!(sel_b ? est_valid_b : est_valid_a)) cyc = -1;
   endtask

   initial begin
      int  cyc;
      bit  seen;

      vecs[0] = '{240, 240, 1'b1, 1, 1, 'h8000};
      vecs[1] = '{  0,   0, 1'b1, 1, 2, 'h4000};
      vecs[2] = '{  0, 240, 1'b1, 2, 3, 'h5555};
      vecs[3] = '{481,  10, 1'b0, 2, 3, 'h5555};
      vecs[4] = '{480, 480, 1'b1, 2, 4, 'h4000};
      vecs[5] = '{100, 400, 1'b1, 3, 5, 'h4ccc};
      vecs[6] = '{511, 511, 1'b0, 3, 5, 'h4ccc};

      reset = 1'b1;
      stb_a = 1'b0;
      stb_b = 1'b0;
      x     = '0;
      y     = '0;
      repeat (3) @(negedge clk10);
      reset = 1'b0;

      check("reset_hit",       int'(hit_a),       0);
      check("reset_total",     int'(total_a),     0);
      check("reset_pi",        int'(pi_a),        0);
      check("reset_est_valid", int'(est_valid_a), 0);
      check("reset_overrun",   int'(overrun_a),   0);
      check("reset_saturated", int'(saturated_a), 0);
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk10);
         if (busy_a || est_valid_a || busy_b) seen = 1'b1;
      end
      check("idle_no_activity", int'(seen), 0);

      for (int i = 0; i < 7; i++) begin
         strobe(1'b0, vecs[i].x, vecs[i].y);
         wait_valid(1'b0, 60, cyc);
         check($sformatf("vec%0d_latency", i), cyc, vecs[i].valid ? 39 : -1);
         check($sformatf("vec%0d_hit", i),   int'(hit_a),   vecs[i].hit);
         check($sformatf("vec%0d_total", i), int'(total_a), vecs[i].total);
         check($sformatf("vec%0d_pi", i),    int'(pi_a),    vecs[i].pi);
      end

      // Second strobe five cycles after the first is dropped
      check("overrun_before", int'(overrun_a), 0);
      strobe(1'b0, 240, 240);
      check("busy_in_calc", int'(busy_a), 1);
      repeat (3) @(negedge clk10);
      strobe(1'b0, 0, 0);
      check("overrun_set", int'(overrun_a), 1);
      wait_valid(1'b0, 60, cyc);
      check("overrun_latency", cyc, 34);
      check("overrun_hit",   int'(hit_a),   4);
      check("overrun_total", int'(total_a), 6);
      check("overrun_pi",    int'(pi_a),    'h5555);
      @(negedge clk10);
      wait_valid(1'b0, 60, cyc);
      check("overrun_no_second_est", cyc, -1);
      check("overrun_total_after", int'(total_a), 6);
      check("overrun_sticky", int'(overrun_a), 1);

      // COUNT_W=4: counters freeze at 15 and the 16th sample is ignored
      for (int i = 1; i <= 16; i++) begin
         strobe(1'b1, 240, 240);
         wait_valid(1'b1, 40, cyc);
         if (i <= 15) begin
            check($sformatf("sat%0d_latency", i), cyc, 23);
            check($sformatf("sat%0d_total", i), int'(total_b), i);
         end else begin
            check("sat16_no_est", cyc, -1);
            check("sat16_total", int'(total_b), 15);
            check("sat16_hit", int'(hit_b), 15);
            check("sat16_saturated", int'(saturated_b), 1);
            check("sat16_pi", int'(pi_b), 'h8000);
            check("sat16_no_overrun", int'(overrun_b), 0);
         end
      end

      // Reset during DIV discards the partial result
      strobe(1'b0, 240, 240);
      repeat (10) @(negedge clk10);
      check("mid_div_busy", int'(busy_a), 1);
      reset = 1'b1;
      @(negedge clk10);
      reset = 1'b0;
      check("mid_rst_busy",      int'(busy_a),      0);
      check("mid_rst_hit",       int'(hit_a),       0);
      check("mid_rst_total",     int'(total_a),     0);
      check("mid_rst_pi",        int'(pi_a),        0);
      check("mid_rst_est_valid", int'(est_valid_a), 0);
      check("mid_rst_overrun",   int'(overrun_a),   0);
      check("mid_rst_sat_b",     int'(saturated_b), 0);
      check("mid_rst_total_b",   int'(total_b),     0);
      wait_valid(1'b0, 60, cyc);
      check("mid_rst_no_est", cyc, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
